// File: rtl/uart_rx_pkg.sv
// Shared constants and types for the UART receiver: bit timing, MMIO map, FSM states.
package uart_rx_pkg;

  localparam int          UART_CLKS_PER_BIT = 68;
  localparam logic [31:0] UART_RX_DATA      = 32'h8000_000C;
  localparam logic [31:0] UART_RX_STAT      = 32'h8000_0010;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// CPU-facing side of the UART receiver: pop/clear strobes in, FIFO head and status out.
interface uart_rx_if #(
  parameter int FIFO_DEPTH = 4
);

  logic                          rd_en;
  logic                          err_clr;
  logic [7:0]                    rd_data;
  logic                          rx_avail;
  logic [$clog2(FIFO_DEPTH):0]   rx_count;
  logic                          frame_err;
  logic                          overrun;

  modport master (
    output rd_en, err_clr,
    input  rd_data, rx_avail, rx_count, frame_err, overrun
  );

  modport slave (
    input  rd_en, err_clr,
    output rd_data, rx_avail, rx_count, frame_err, overrun
  );

endinterface

// File: rtl/uart_rx_sync_fifo.sv
// Show-ahead synchronous FIFO with an explicit occupancy count; head is readable without a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // A simultaneous pop frees the slot, so a write into a full FIFO still succeeds.
  always_comb begin
    do_pop   = rd_en && (count_q != '0);
    do_push  = wr_en && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronise rx, mid-bit sample LSB first, queue bytes in a show-ahead FIFO.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  uart_rx_if.slave   bus
);

  localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int               CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  logic             sync1_q, rx_s_q, rx_prev_q;
  uart_rx_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       data_q, data_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             push, frame_set, overrun_set;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    push      = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      RX_IDLE: begin
        // Edge-triggered start so a held-low break cannot re-arm reception.
        if (rx_prev_q && !rx_s_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = RX_DATA;
            bit_idx_d = '0;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d             = '0;
          data_d[bit_idx_q] = rx_s_q;
          bit_idx_d         = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = RX_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          state_d   = RX_IDLE;
          push      = rx_s_q;
          frame_set = !rx_s_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // A pop in the same cycle makes room, so only an unserviced full FIFO drops the byte.
  always_comb begin
    overrun_set = push && fifo_full && !bus.rd_en;
    frame_err_d = (frame_err_q && !bus.err_clr) || frame_set;
    overrun_d   = (overrun_q && !bus.err_clr) || overrun_set;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      data_q      <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= rx;
      rx_s_q      <= sync1_q;
      rx_prev_q   <= rx_s_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      data_q      <= data_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (data_q),
    .rd_en   (bus.rd_en),
    .rd_data (bus.rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bus.rx_avail  = !fifo_empty;
  assign bus.rx_count  = fifo_count;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx: an 8N1 line driver feeds bytes, a monitor checks every pop.
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int C     = 8;
  localparam int DEPTH = 4;
  localparam int LAT   = 2 + C / 2 + 9 * C;

  logic clk;
  logic rst_n;
  logic rx;
  int   errors;
  int   checks;
  logic [7:0] exp_q[$];

  uart_rx_if #(.FIFO_DEPTH(DEPTH)) bus();

  uart_rx #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (C) @(negedge clk);
    end
    rx = stop_bit;
    repeat (C) @(negedge clk);
    rx = 1'b1;
    $display("sent byte %02h stop=%0b", b, stop_bit);
  endtask

  task automatic pop();
    @(negedge clk);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic clear_errors();
    @(negedge clk);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every accepted pop is compared against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (bus.rd_en && bus.rx_avail) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected: got %02h expected no byte", bus.rd_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (bus.rd_data !== e) begin
            errors++;
            $display("FAIL pop_data: got %02h expected %02h", bus.rd_data, e);
          end else begin
            $display("pop byte %02h", bus.rd_data);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    errors      = 0;
    checks      = 0;
    rx          = 1'b1;
    rst_n       = 1'b0;
    bus.rd_en   = 1'b0;
    bus.err_clr = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    check("reset_avail", 32'(bus.rx_avail), 32'd0);
    check("reset_count", 32'(bus.rx_count), 32'd0);
    check("reset_data",  32'(bus.rd_data), 32'd0);
    check("reset_ferr",  32'(bus.frame_err), 32'd0);
    check("reset_ovr",   32'(bus.overrun), 32'd0);

    // Single byte with latency measurement: first posedge seeing rx low counts as 1.
    exp_q.push_back(8'h55);
    cyc = 0;
    fork
      send_byte(8'h55, 1'b1);
      begin
        @(negedge clk);
        while (cyc < 200) begin
          @(posedge clk);
          #1;
          cyc++;
          if (bus.rx_avail) break;
        end
      end
    join
    check("latency", 32'(cyc), 32'(LAT + 1));
    check("single_count", 32'(bus.rx_count), 32'd1);
    check("single_data", 32'(bus.rd_data), 32'h55);
    pop();
    check("single_count_after_pop", 32'(bus.rx_count), 32'd0);

    // rd_en on empty FIFO is harmless.
    pop();
    check("empty_pop_count", 32'(bus.rx_count), 32'd0);
    check("empty_pop_ovr", 32'(bus.overrun), 32'd0);

    // Back-to-back frames.
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hFF);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'hFF, 1'b1);
    idle(4);
    check("b2b_count", 32'(bus.rx_count), 32'd3);
    check("b2b_ferr", 32'(bus.frame_err), 32'd0);
    check("b2b_ovr", 32'(bus.overrun), 32'd0);
    repeat (3) pop();
    check("b2b_drained", 32'(bus.rx_count), 32'd0);

    // Short low glitch is rejected at the mid-start sample.
    @(negedge clk);
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(20);
    $display("glitch applied");
    check("glitch_count", 32'(bus.rx_count), 32'd0);
    check("glitch_state", 32'(dut.state_q), 32'(RX_IDLE));
    check("glitch_ferr", 32'(bus.frame_err), 32'd0);

    // Framing error, then clear.
    send_byte(8'h12, 1'b0);
    idle(4);
    check("ferr_set", 32'(bus.frame_err), 32'd1);
    check("ferr_count", 32'(bus.rx_count), 32'd0);
    clear_errors();
    check("ferr_cleared", 32'(bus.frame_err), 32'd0);

    // Overrun: fifth byte dropped.
    for (int i = 1; i <= 5; i++) begin
      if (i <= DEPTH) exp_q.push_back(8'(i));
      send_byte(8'(i), 1'b1);
    end
    idle(4);
    check("ovr_count", 32'(bus.rx_count), 32'd4);
    check("ovr_set", 32'(bus.overrun), 32'd1);
    repeat (4) pop();
    check("ovr_drained", 32'(bus.rx_count), 32'd0);
    clear_errors();
    check("ovr_cleared", 32'(bus.overrun), 32'd0);

    // Full FIFO with a pop on the push edge: no overrun, count stays at depth.
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h10 + 8'(i));
      send_byte(8'h10 + 8'(i), 1'b1);
    end
    idle(2);
    check("full_count", 32'(bus.rx_count), 32'd4);
    exp_q.push_back(8'h14);
    fork
      send_byte(8'h14, 1'b1);
      begin
        @(negedge clk);
        idle(LAT);
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
      end
    join
    idle(2);
    check("simul_ovr", 32'(bus.overrun), 32'd0);
    check("simul_count", 32'(bus.rx_count), 32'd4);
    repeat (4) pop();
    check("simul_drained", 32'(bus.rx_count), 32'd0);

    // Leave a byte queued and a flag set, then reset in the middle of a frame.
    send_byte(8'h12, 1'b0);
    send_byte(8'h99, 1'b1);
    idle(2);
    check("pre_reset_count", 32'(bus.rx_count), 32'd1);
    @(negedge clk);
    rx = 1'b0;
    idle(C);
    rx = 1'b1;
    idle(C);
    rx = 1'b0;
    idle(C / 2);
    rst_n = 1'b0;
    rx    = 1'b1;
    idle(2);
    rst_n = 1'b1;
    #1;
    $display("reset applied mid-frame");
    check("midrst_avail", 32'(bus.rx_avail), 32'd0);
    check("midrst_count", 32'(bus.rx_count), 32'd0);
    check("midrst_data", 32'(bus.rd_data), 32'd0);
    check("midrst_ferr", 32'(bus.frame_err), 32'd0);
    check("midrst_ovr", 32'(bus.overrun), 32'd0);
    idle(12 * C);
    check("midrst_no_push", 32'(bus.rx_count), 32'd0);
    check("midrst_state", 32'(dut.state_q), 32'(RX_IDLE));

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
